// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address width and byte merge.
// Words up to MAX_W bits are supported; callers zero-extend in and truncate out.
package regfile_pkg;

  localparam int MAX_W     = 512;
  localparam int MAX_BYTES = MAX_W / 8;

  typedef logic [MAX_W-1:0]     word_t;
  typedef logic [MAX_BYTES-1:0] be_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Enabled bytes come from new_w, the rest keep old_w.
  function automatic word_t merge(input word_t old_w, input word_t new_w, input be_t be);
    word_t r;
    r = old_w;
    for (int b = 0; b < MAX_BYTES; b++)
      if (be[b]) r[b*8 +: 8] = new_w[b*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: address decode, write-first bypass, rdata/rvalid regs.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int BYTES  = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          re,
  input  logic [AW-1:0]                 raddr,
  input  logic                          we,
  input  logic [AW-1:0]                 waddr,
  input  logic [DATA_W-1:0]             wdata,
  input  logic [BYTES-1:0]              wbe,
  input  logic [DEPTH-1:0][DATA_W-1:0]  mem,
  output logic [DATA_W-1:0]             rdata,
  output logic                          rvalid
);

  logic [DATA_W-1:0] stored;
  logic [DATA_W-1:0] rd_nxt;
  logic              hit;

  // Equality decode keeps out-of-range addresses at zero without a range compare.
  always_comb begin
    stored = '0;
    hit    = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      if (raddr == AW'(k)) begin
        stored = mem[k];
        hit    = 1'b1;
      end
    rd_nxt = stored;
    if (clr || !hit)
      rd_nxt = '0;
    else if (we && (waddr == raddr))
      rd_nxt = DATA_W'(merge(word_t'(stored), word_t'(wdata), be_t'(wbe)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= rd_nxt;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file: byte-masked write port, N_RD bypassed read ports,
// synchronous clear, per-word written flags and a flat view of all words.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 8,
  parameter  int N_RD   = 2,
  localparam int AW     = clog2(DEPTH),
  localparam int BYTES  = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [BYTES-1:0]         wbe,
  input  logic [N_RD-1:0]          re,
  input  logic [N_RD*AW-1:0]       raddr,
  output logic [N_RD*DATA_W-1:0]   rdata,
  output logic [N_RD-1:0]          rvalid,
  output logic [DEPTH-1:0]         written,
  output logic [DEPTH*DATA_W-1:0]  q_all
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0][DATA_W-1:0] mem_nxt;

  for (genvar k = 0; k < DEPTH; k++) begin : g_word
    assign mem_nxt[k] = DATA_W'(merge(word_t'(mem[k]), word_t'(wdata), be_t'(wbe)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= '0;
      written <= '0;
    end else if (clr) begin
      mem     <= '0;
      written <= '0;
    end else if (we) begin
      for (int k = 0; k < DEPTH; k++)
        if (waddr == AW'(k)) begin
          mem[k]     <= mem_nxt[k];
          written[k] <= 1'b1;
        end
    end
  end

  assign q_all = mem;

  for (genvar i = 0; i < N_RD; i++) begin : g_rd
    regfile_rd_port #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW),
      .BYTES  (BYTES)
    ) u_rd (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (clr),
      .re     (re[i]),
      .raddr  (raddr[i*AW +: AW]),
      .we     (we),
      .waddr  (waddr),
      .wdata  (wdata),
      .wbe    (wbe),
      .mem    (mem),
      .rdata  (rdata[i*DATA_W +: DATA_W]),
      .rvalid (rvalid[i])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios on the default config, then a DEPTH=6,
// N_RD=3, DATA_W=32 instance for out-of-range and randomized checks against a model.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance: DATA_W=64, DEPTH=8, N_RD=2
  logic         clr0 = 0, we0 = 0;
  logic [2:0]   waddr0 = 0;
  logic [63:0]  wdata0 = 0;
  logic [7:0]   wbe0 = 0;
  logic [1:0]   re0 = 0;
  logic [5:0]   raddr0 = 0;
  logic [127:0] rdata0;
  logic [1:0]   rvalid0;
  logic [7:0]   written0;
  logic [511:0] q_all0;

  // small instance: DATA_W=32, DEPTH=6, N_RD=3
  logic         clr1 = 0, we1 = 0;
  logic [2:0]   waddr1 = 0;
  logic [31:0]  wdata1 = 0;
  logic [3:0]   wbe1 = 0;
  logic [2:0]   re1 = 0;
  logic [8:0]   raddr1 = 0;
  logic [95:0]  rdata1;
  logic [2:0]   rvalid1;
  logic [5:0]   written1;
  logic [191:0] q_all1;

  regfile_mp dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr0), .we(we0), .waddr(waddr0), .wdata(wdata0),
    .wbe(wbe0), .re(re0), .raddr(raddr0), .rdata(rdata0), .rvalid(rvalid0),
    .written(written0), .q_all(q_all0)
  );

  regfile_mp #(.DATA_W(32), .DEPTH(6), .N_RD(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr1), .we(we1), .waddr(waddr1), .wdata(wdata1),
    .wbe(wbe1), .re(re1), .raddr(raddr1), .rdata(rdata1), .rvalid(rvalid1),
    .written(written1), .q_all(q_all1)
  );

  int nvec = 0;
  int nerr = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  task automatic test_reset_state();
    #2;
    nvec++; if (rdata0 !== '0)   begin nerr++; $display("FAIL reset_rdata got %h exp 0", rdata0); end
    nvec++; if (rvalid0 !== '0)  begin nerr++; $display("FAIL reset_rvalid got %b exp 0", rvalid0); end
    nvec++; if (written0 !== '0) begin nerr++; $display("FAIL reset_written got %b exp 0", written0); end
    nvec++; if (q_all0 !== '0)   begin nerr++; $display("FAIL reset_q_all got %h exp 0", q_all0); end
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    we0 = 1; waddr0 = 3; wdata0 = 64'hDEAD_BEEF_0123_4567; wbe0 = 8'hFF;
    step();
    nvec++; if (written0 !== 8'b0000_1000) begin nerr++; $display("FAIL wr_written got %b exp 00001000", written0); end
    nvec++; if (q_all0[255:192] !== 64'hDEAD_BEEF_0123_4567)
      begin nerr++; $display("FAIL wr_q_all got %h exp deadbeef01234567", q_all0[255:192]); end
    we0 = 0; re0 = 2'b01; raddr0 = 6'd3;
    step();
    nvec++; if (rdata0[63:0] !== 64'hDEAD_BEEF_0123_4567)
      begin nerr++; $display("FAIL rd_data got %h exp deadbeef01234567", rdata0[63:0]); end
    nvec++; if (rvalid0 !== 2'b01) begin nerr++; $display("FAIL rd_valid got %b exp 01", rvalid0); end
    re0 = 0;
    step();
    nvec++; if (rvalid0 !== 2'b00 || rdata0[63:0] !== 64'hDEAD_BEEF_0123_4567)
      begin nerr++; $display("FAIL rd_hold got %b/%h exp 00/deadbeef01234567", rvalid0, rdata0[63:0]); end
  endtask

  task automatic test_bypass();
    we0 = 1; waddr0 = 5; wdata0 = 64'h1111_1111_1111_1111; wbe0 = 8'hFF;
    step();
    wdata0 = '1; wbe0 = 8'h0F; re0 = 2'b11; raddr0 = {3'd5, 3'd5};
    step();
    we0 = 0; re0 = 0;
    nvec++; if (rdata0[63:0] !== 64'h1111_1111_FFFF_FFFF)
      begin nerr++; $display("FAIL bypass_p0 got %h exp 11111111ffffffff", rdata0[63:0]); end
    nvec++; if (rdata0[127:64] !== 64'h1111_1111_FFFF_FFFF)
      begin nerr++; $display("FAIL bypass_p1 got %h exp 11111111ffffffff", rdata0[127:64]); end
    nvec++; if (rvalid0 !== 2'b11) begin nerr++; $display("FAIL bypass_valid got %b exp 11", rvalid0); end
    nvec++; if (q_all0[383:320] !== 64'h1111_1111_FFFF_FFFF)
      begin nerr++; $display("FAIL bypass_store got %h exp 11111111ffffffff", q_all0[383:320]); end
  endtask

  task automatic test_clr();
    we0 = 1; waddr0 = 2; wdata0 = 64'h0BAD_F00D_0BAD_F00D; wbe0 = 8'hFF;
    step();
    clr0 = 1; wdata0 = 64'h5555_AAAA_5555_AAAA; re0 = 2'b10; raddr0 = {3'd2, 3'd0};
    step();
    clr0 = 0; we0 = 0; re0 = 0;
    nvec++; if (rdata0[127:64] !== '0) begin nerr++; $display("FAIL clr_rdata got %h exp 0", rdata0[127:64]); end
    nvec++; if (rvalid0 !== 2'b10) begin nerr++; $display("FAIL clr_rvalid got %b exp 10", rvalid0); end
    nvec++; if (written0 !== '0) begin nerr++; $display("FAIL clr_written got %b exp 0", written0); end
    nvec++; if (q_all0 !== '0) begin nerr++; $display("FAIL clr_q_all got %h exp 0", q_all0); end
  endtask

  task automatic test_reset_mid();
    we0 = 1; waddr0 = 1; wdata0 = 64'hCAFE_0000_1234_5678; wbe0 = 8'hFF;
    step();
    we0 = 0; re0 = 2'b01; raddr0 = 6'd1;
    step();
    re0 = 0;
    nvec++; if (rdata0[63:0] !== 64'hCAFE_0000_1234_5678)
      begin nerr++; $display("FAIL prereset_rdata got %h exp cafe000012345678", rdata0[63:0]); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (rdata0 !== '0)   begin nerr++; $display("FAIL midreset_rdata got %h exp 0", rdata0); end
    nvec++; if (rvalid0 !== '0)  begin nerr++; $display("FAIL midreset_rvalid got %b exp 0", rvalid0); end
    nvec++; if (written0 !== '0) begin nerr++; $display("FAIL midreset_written got %b exp 0", written0); end
    nvec++; if (q_all0 !== '0)   begin nerr++; $display("FAIL midreset_q_all got %h exp 0", q_all0); end
    #1 rst_n = 1'b1;
  endtask

  task automatic test_out_of_range();
    we1 = 1; waddr1 = 3'd7; wdata1 = 32'hA5A5_A5A5; wbe1 = 4'hF;
    re1 = 3'b011; raddr1 = {3'd0, 3'd7, 3'd6};
    step();
    we1 = 0; re1 = 0;
    nvec++; if (written1 !== '0) begin nerr++; $display("FAIL oor_written got %b exp 0", written1); end
    nvec++; if (q_all1 !== '0)   begin nerr++; $display("FAIL oor_q_all got %h exp 0", q_all1); end
    nvec++; if (rdata1[63:0] !== '0) begin nerr++; $display("FAIL oor_rdata got %h exp 0", rdata1[63:0]); end
    nvec++; if (rvalid1 !== 3'b011) begin nerr++; $display("FAIL oor_rvalid got %b exp 011", rvalid1); end
  endtask

  task automatic test_random(input int cycles);
    logic [31:0]  m_mem [6];
    logic [5:0]   m_wr;
    logic [31:0]  m_rd  [3];
    logic [2:0]   m_rv;
    logic [191:0] exp_q;
    int           shown;
    for (int k = 0; k < 6; k++) m_mem[k] = '0;
    for (int i = 0; i < 3; i++) m_rd[i] = '0;
    m_wr = '0; m_rv = '0; shown = 0;
    for (int c = 0; c < cycles; c++) begin
      we1    = 1'($urandom);
      waddr1 = 3'($urandom);
      wdata1 = $urandom;
      wbe1   = 4'($urandom);
      re1    = 3'($urandom);
      raddr1 = 9'($urandom);
      clr1   = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < 3; i++) begin
        int a;
        a = int'(raddr1[i*3 +: 3]);
        m_rv[i] = re1[i];
        if (re1[i]) begin
          if (clr1 || a >= 6)                 m_rd[i] = '0;
          else if (we1 && int'(waddr1) == a)  m_rd[i] = merge32(m_mem[a], wdata1, wbe1);
          else                                m_rd[i] = m_mem[a];
        end
      end
      if (clr1) begin
        for (int k = 0; k < 6; k++) m_mem[k] = '0;
        m_wr = '0;
      end else if (we1 && waddr1 < 6) begin
        m_mem[waddr1] = merge32(m_mem[waddr1], wdata1, wbe1);
        m_wr[waddr1]  = 1'b1;
      end
      for (int k = 0; k < 6; k++) exp_q[k*32 +: 32] = m_mem[k];
      step();
      for (int i = 0; i < 3; i++) begin
        nvec++;
        if (rdata1[i*32 +: 32] !== m_rd[i] || rvalid1[i] !== m_rv[i]) begin
          nerr++;
          if (shown++ < 10)
            $display("FAIL rand_port%0d cyc %0d got %h/%b exp %h/%b",
                     i, c, rdata1[i*32 +: 32], rvalid1[i], m_rd[i], m_rv[i]);
        end
      end
      nvec++;
      if (written1 !== m_wr) begin
        nerr++;
        if (shown++ < 10) $display("FAIL rand_written cyc %0d got %b exp %b", c, written1, m_wr);
      end
      nvec++;
      if (q_all1 !== exp_q) begin
        nerr++;
        if (shown++ < 10) $display("FAIL rand_q_all cyc %0d got %h exp %h", c, q_all1, exp_q);
      end
    end
    we1 = 0; re1 = 0; clr1 = 0;
  endtask

  initial begin
    test_reset_state();
    test_write_read();
    test_bypass();
    test_clr();
    test_reset_mid();
    test_out_of_range();
    test_random(10000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
